// File: rtl/periph_bus_pkg.sv
// Shared definitions for the CPU-to-peripheral byte-lane bridge.
package periph_bus_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/periph_bridge_if.sv
// Signal bundle for the bridge: req/gnt handshake on the CPU side, byte strobes on the peripheral side.
// A request is taken on the rising edge where req and gnt are both high; rvalid pulses for one cycle at completion.
interface periph_bridge_if #(
    parameter int PADDR_W = 3
);
    logic               req;
    logic               we;
    logic [PADDR_W-1:0] addr;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic               gnt;
    logic               rvalid;
    logic [31:0]        rdata;
    logic               p_write;
    logic [PADDR_W-1:0] p_addr;
    logic [31:0]        p_wdata;
    logic [31:0]        p_rdata;

    modport master (
        output req, we, addr, be, wdata, p_rdata,
        input  gnt, rvalid, rdata, p_write, p_addr, p_wdata
    );

    modport slave (
        input  req, we, addr, be, wdata, p_rdata,
        output gnt, rvalid, rdata, p_write, p_addr, p_wdata
    );

endinterface

// File: rtl/periph_bridge.sv
// Splits a 32-bit word request into one byte access per enabled lane on an
// 8-bit-wide peripheral, assembling read bytes back into a word.
module periph_bridge
    import periph_bus_pkg::*;
#(
    parameter int PADDR_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [PADDR_W-1:0] addr_i,
    input  logic [3:0]         be_i,
    input  logic [31:0]        wdata_i,
    output logic               gnt_o,
    output logic               rvalid_o,
    output logic [31:0]        rdata_o,
    output logic               p_write_o,
    output logic [PADDR_W-1:0] p_addr_o,
    output logic [31:0]        p_wdata_o,
    input  logic [31:0]        p_rdata_i
);

    state_e             r_state;
    state_e             w_state_next;
    logic               r_we;
    logic [PADDR_W-1:0] r_addr;
    logic [3:0]         r_pend;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;

    logic               w_accept;
    logic               w_access;
    logic [1:0]         w_lane;
    logic [3:0]         w_pend_next;
    logic [7:0]         w_wbyte;

    assign gnt_o    = (r_state == IDLE);
    assign w_accept = req_i & gnt_o;
    assign w_access = (r_state == ACCESS);

    // Lowest still-pending lane is the one served this cycle.
    always_comb begin
        w_lane = 2'd0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (r_pend[k]) begin
                w_lane = 2'(k);
            end
        end
    end

    assign w_pend_next = r_pend & ~(4'b0001 << w_lane);
    assign w_wbyte     = r_wdata[{w_lane, 3'b000} +: 8];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (be_i != 4'b0000) ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (w_pend_next == 4'b0000) begin
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Result word is cleared on accept so disabled lanes and writes return zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_pend  <= 4'b0000;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
        end else if (w_accept) begin
            r_we    <= we_i;
            r_addr  <= addr_i & ~PADDR_W'(3);
            r_pend  <= be_i;
            r_wdata <= wdata_i;
            r_rdata <= 32'h0;
        end else if (w_access) begin
            r_pend <= w_pend_next;
            if (!r_we) begin
                r_rdata[{w_lane, 3'b000} +: 8] <= p_rdata_i[{w_lane, 3'b000} +: 8];
            end
        end
    end

    assign rvalid_o  = (r_state == RESP);
    assign rdata_o   = rvalid_o ? r_rdata : 32'h0;
    assign p_write_o = w_access & r_we;
    assign p_addr_o  = w_access ? (r_addr | PADDR_W'(w_lane)) : '0;
    assign p_wdata_o = w_access ? {4{w_wbyte}} : 32'h0;

endmodule

// File: tb/tb_periph_bridge.sv
// Directed bench for periph_bridge: vector table for single transactions plus
// hand-written reset-abort and back-to-back request sequences.
module tb_periph_bridge;

    localparam int PADDR_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    periph_bridge_if #(.PADDR_W(PADDR_W)) bus ();

    periph_bridge #(.PADDR_W(PADDR_W)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (bus.req),
        .we_i      (bus.we),
        .addr_i    (bus.addr),
        .be_i      (bus.be),
        .wdata_i   (bus.wdata),
        .gnt_o     (bus.gnt),
        .rvalid_o  (bus.rvalid),
        .rdata_o   (bus.rdata),
        .p_write_o (bus.p_write),
        .p_addr_o  (bus.p_addr),
        .p_wdata_o (bus.p_wdata),
        .p_rdata_i (bus.p_rdata)
    );

    // Peripheral: one byte per address, returned at its natural lane only.
    logic [7:0] mem [8];
    assign bus.p_rdata = {24'h0, mem[bus.p_addr]} << {bus.p_addr[1:0], 3'b000};

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        int         lat;
        int         nacc;
        int         nl;
        int         lanes[4];
        logic [31:0] got_rdata;
        nl = 0;
        for (int k = 0; k < 4; k++) begin
            if (v.be[k]) begin
                lanes[nl] = k;
                nl++;
            end
        end
        @(negedge clk);
        check32({v.name, "_gnt_idle"}, 32'(bus.gnt), 32'd1);
        bus.req   = 1'b1;
        bus.we    = v.we;
        bus.addr  = v.addr;
        bus.be    = v.be;
        bus.wdata = v.wdata;
        @(posedge clk);
        #1;
        bus.req   = 1'b0;
        bus.we    = ~v.we;
        bus.addr  = 3'($urandom_range(0, 7));
        bus.be    = 4'($urandom_range(0, 15));
        bus.wdata = $urandom;
        lat       = 0;
        nacc      = 0;
        got_rdata = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.rvalid) begin
                lat       = c;
                got_rdata = bus.rdata;
                check32({v.name, "_resp_pwrite"}, 32'(bus.p_write), 32'd0);
                check32({v.name, "_resp_paddr"}, 32'(bus.p_addr), 32'd0);
                check32({v.name, "_resp_pwdata"}, bus.p_wdata, 32'h0);
                break;
            end
            if (nacc < nl) begin
                check32({v.name, "_acc_gnt"}, 32'(bus.gnt), 32'd0);
                check32({v.name, "_acc_paddr"}, 32'(bus.p_addr), 32'({v.addr[2], 2'(lanes[nacc])}));
                check32({v.name, "_acc_pwrite"}, 32'(bus.p_write), 32'(v.we));
                check32({v.name, "_acc_pwdata"}, bus.p_wdata, {4{v.wdata[8*lanes[nacc] +: 8]}});
                nacc++;
            end else begin
                check32({v.name, "_extra_cycle"}, 32'(c), 32'(v.exp_lat));
            end
        end
        check32({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check32({v.name, "_naccess"}, 32'(nacc), 32'(nl));
        check32({v.name, "_rdata"}, got_rdata, v.exp_rdata);
        @(negedge clk);
        check32({v.name, "_after_rvalid"}, 32'(bus.rvalid), 32'd0);
        check32({v.name, "_after_gnt"}, 32'(bus.gnt), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        mem[1] = 8'hBE;

        vecs[0] = '{"w_a4_b0011", 1'b1, 3'd4, 4'b0011, 32'h0000_A55A, 32'h0000_0000, 3};
        vecs[1] = '{"r_a0_b0010", 1'b0, 3'd0, 4'b0010, 32'h0000_0000, 32'h0000_BE00, 2};
        vecs[2] = '{"r_a4_b1001", 1'b0, 3'd4, 4'b1001, 32'hFFFF_FFFF, 32'h1700_0014, 3};
        vecs[3] = '{"r_a0_b0000", 1'b0, 3'd0, 4'b0000, 32'h1234_5678, 32'h0000_0000, 1};
        vecs[4] = '{"r_a4_b1111", 1'b0, 3'd4, 4'b1111, 32'h0000_0000, 32'h1716_1514, 5};
        vecs[5] = '{"w_a0_b0100", 1'b1, 3'd0, 4'b0100, 32'h1122_3344, 32'h0000_0000, 2};
        vecs[6] = '{"r_a6_b0001", 1'b0, 3'd6, 4'b0001, 32'h0000_0000, 32'h0000_0014, 2};
        vecs[7] = '{"r_a3_b1100", 1'b0, 3'd3, 4'b1100, 32'h0000_0000, 32'h1312_0000, 3};

        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.be    = 4'b0000;
        bus.wdata = 32'h0;

        // Reset state
        @(negedge clk);
        check32("rst_gnt", 32'(bus.gnt), 32'd1);
        check32("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check32("rst_rdata", bus.rdata, 32'h0);
        check32("rst_pwrite", 32'(bus.p_write), 32'd0);
        check32("rst_paddr", 32'(bus.p_addr), 32'd0);
        check32("rst_pwdata", bus.p_wdata, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset during the second lane of a full-word write
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 3'd4;
        bus.be    = 4'b1111;
        bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(negedge clk);
        check32("abort_acc1_paddr", 32'(bus.p_addr), 32'd4);
        check32("abort_acc1_pwdata", bus.p_wdata, 32'hEFEF_EFEF);
        @(negedge clk);
        check32("abort_acc2_paddr", 32'(bus.p_addr), 32'd5);
        check32("abort_acc2_pwrite", 32'(bus.p_write), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check32("abort_pwrite", 32'(bus.p_write), 32'd0);
        check32("abort_paddr", 32'(bus.p_addr), 32'd0);
        check32("abort_pwdata", bus.p_wdata, 32'h0);
        check32("abort_gnt", 32'(bus.gnt), 32'd1);
        check32("abort_rvalid", 32'(bus.rvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check32("abort_post_rvalid", 32'(bus.rvalid), 32'd0);
            check32("abort_post_gnt", 32'(bus.gnt), 32'd1);
            check32("abort_post_pwrite", 32'(bus.p_write), 32'd0);
        end

        // Request held high: accepts every third cycle
        bus.req   = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 3'd0;
        bus.be    = 4'b0001;
        bus.wdata = 32'h0;
        for (int c = 0; c < 9; c++) begin
            check32("held_gnt", 32'(bus.gnt), (c % 3 == 0) ? 32'd1 : 32'd0);
            check32("held_rvalid", 32'(bus.rvalid), (c % 3 == 2) ? 32'd1 : 32'd0);
            if (c % 3 == 1) check32("held_pwrite", 32'(bus.p_write), 32'd0);
            if (c % 3 == 2) check32("held_rdata", bus.rdata, 32'h0000_0010);
            @(negedge clk);
        end
        bus.req = 1'b0;
        repeat (4) @(negedge clk);
        check32("final_gnt", 32'(bus.gnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_bridge.md
PERIPH_BRIDGE -- requirements
Module: periph_bridge

Interface
REQ-001 SHALL have parameter PADDR_W, default 3, peripheral byte-address width (minimum 2).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_i  input  1  CPU-side request valid.
REQ-005 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-006 SHALL have port addr_i  input  PADDR_W  byte address; bits [1:0] ignored (word aligned).
REQ-007 SHALL have port be_i  input  4  byte-lane enables, bit k = byte lane k.
REQ-008 SHALL have port wdata_i  input  32  write data, lane k = wdata_i[8k+7:8k].
REQ-009 SHALL have port gnt_o  output  1  request accepted this cycle when high with req_i.
REQ-010 SHALL have port rvalid_o  output  1  one-cycle completion pulse (reads and writes).
REQ-011 SHALL have port rdata_o  output  32  assembled read data, valid while rvalid_o high.
REQ-012 SHALL have port p_write_o  output  1  peripheral write strobe.
REQ-013 SHALL have port p_addr_o  output  PADDR_W  peripheral byte address.
REQ-014 SHALL have port p_wdata_o  output  32  peripheral write data.
REQ-015 SHALL have port p_rdata_i  input  32  peripheral read data, combinational from p_addr_o, byte at its natural lane.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-017 SHALL drive gnt_o = 1 only in IDLE; accept = req_i & gnt_o at cycle T latches we_i, addr_i[PADDR_W-1:2], be_i, wdata_i.
REQ-018 On accept with be_i != 0 SHALL go IDLE->ACCESS; with be_i == 0 SHALL go IDLE->RESP with no peripheral access.
REQ-019 In ACCESS SHALL perform one byte access per cycle for each set enable bit, ascending lane order (0 to 3), skipping clear bits, no idle cycles between.
REQ-020 During access to lane k SHALL drive p_addr_o = {latched addr[PADDR_W-1:2], k[1:0]}, p_write_o = latched we, p_wdata_o = latched byte k replicated in all four lanes.
REQ-021 On read access to lane k SHALL capture p_rdata_i[8k+7:8k] into result lane k in that cycle.
REQ-022 After the last enabled lane SHALL go ACCESS->RESP; RESP->IDLE unconditionally next cycle.
REQ-023 With N set enable bits, accesses SHALL occupy cycles T+1..T+N and rvalid_o SHALL be high exactly at cycle T+N+1 (T+1 when N=0).
REQ-024 rdata_o SHALL hold captured lanes for enabled lanes and 0 for disabled lanes; SHALL be 0 for writes.
REQ-025 Outside ACCESS SHALL drive p_write_o = 0, p_addr_o = 0, p_wdata_o = 0.
REQ-026 Next request SHALL be accepted no earlier than the cycle after rvalid_o; req_i while busy SHALL be ignored, no queuing.
REQ-027 Inputs req_i/we_i/addr_i/be_i/wdata_i changing after accept SHALL not affect the transaction in flight.

Reset
REQ-028 Asserting rst_ni low SHALL immediately force IDLE, gnt_o = 1, rvalid_o = 0, rdata_o = 0, p_write_o = 0, p_addr_o = 0, p_wdata_o = 0.
REQ-029 Reset mid-ACCESS SHALL abort the transaction with no further peripheral accesses and no rvalid_o pulse.

Structure
REQ-030 SHALL place FSM state enum and lane-count constant (4) in shared package periph_bus_pkg.
REQ-031 SHALL be a single flat module; next-enabled-lane search is inline logic, no sub-module.

Verification
REQ-032 Write addr 0x4, be 0b0011, wdata 0x0000_A55A -> T+1: p_addr 4, p_wdata 0x5A5A_5A5A, write 1; T+2: p_addr 5, p_wdata 0xA5A5_A5A5; rvalid at T+3, rdata 0.
REQ-033 Read addr 0x0, be 0b0010, p_rdata_i model returns 0x0000_BE00 at addr 1 -> one access at T+1 p_addr 1, write 0; rvalid at T+2, rdata 0x0000_BE00.
REQ-034 Read be 0b1001 -> accesses to lanes 0 and 3 on consecutive cycles, lanes 1/2 of rdata 0, rvalid at T+3.
REQ-035 Request with be 0b0000 -> no p_write_o/p_addr_o activity, rvalid at T+1, rdata 0.
REQ-036 rst_ni low during second access of be 0b1111 write -> p_write_o 0 immediately, no rvalid, gnt_o 1 after release.
REQ-037 req_i held high continuously with be 0b0001 -> accepts spaced 3 cycles apart, gnt_o low in ACCESS and RESP.
